// File: rtl/subleq_mem_arbiter.sv
// Two-port (CPU + debug/loader) arbiter in front of a single-port synchronous memory.
// Runs one 3-cycle access at a time, round-robins on contention, and counts CPU stall cycles.
module subleq_mem_arbiter #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 c_req,
    input  logic                 c_we,
    input  logic [WORD_SIZE-1:0] c_addr,
    input  logic [WORD_SIZE-1:0] c_wdata,
    output logic                 c_ack,
    output logic [WORD_SIZE-1:0] c_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_ack,
    output logic [WORD_SIZE-1:0] d_rdata,
    input  logic                 d_hold,
    output logic                 m_en,
    output logic                 m_we,
    output logic [WORD_SIZE-1:0] m_addr,
    output logic [WORD_SIZE-1:0] m_wdata,
    input  logic [WORD_SIZE-1:0] m_rdata,
    output logic [15:0]          c_wait_cnt
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]           state_r;
    logic [1:0]           state_nxt_s;
    logic                 last_dbg_r;
    logic                 sel_dbg_r;
    logic                 lat_we_r;
    logic [WORD_SIZE-1:0] lat_addr_r;
    logic [WORD_SIZE-1:0] lat_wdata_r;
    logic [WORD_SIZE-1:0] c_rdata_r;
    logic [WORD_SIZE-1:0] d_rdata_r;
    logic [15:0]          c_wait_cnt_r;

    logic c_elig_s;
    logic d_elig_s;
    logic grant_s;
    logic grant_dbg_s;

    // Eligibility and round-robin winner selection for the IDLE decision.
    always_comb begin
        c_elig_s    = c_req & ~d_hold;
        d_elig_s    = d_req;
        grant_s     = c_elig_s | d_elig_s;
        // On contention, debug wins only if the CPU was the last port granted.
        grant_dbg_s = d_elig_s & (~c_elig_s | ~last_dbg_r);
    end

    // Next-state logic of the IDLE -> ACCESS -> RESP sequencer.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_nxt_s = ST_ACCESS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS: state_nxt_s = ST_RESP;
            ST_RESP:   state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // State register, grant bookkeeping, operand latch and per-port read data.
    always_ff @(posedge clk) begin
        if (areset) begin
            state_r     <= ST_IDLE;
            last_dbg_r  <= 1'b1;
            sel_dbg_r   <= 1'b0;
            lat_we_r    <= 1'b0;
            lat_addr_r  <= '0;
            lat_wdata_r <= '0;
            c_rdata_r   <= '0;
            d_rdata_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_IDLE && grant_s) begin
                sel_dbg_r   <= grant_dbg_s;
                last_dbg_r  <= grant_dbg_s;
                lat_we_r    <= grant_dbg_s ? d_we    : c_we;
                lat_addr_r  <= grant_dbg_s ? d_addr  : c_addr;
                lat_wdata_r <= grant_dbg_s ? d_wdata : c_wdata;
            end
            // Memory read data is valid during RESP; capture it only for a read.
            if (state_r == ST_RESP && !lat_we_r) begin
                if (sel_dbg_r) begin
                    d_rdata_r <= m_rdata;
                end else begin
                    c_rdata_r <= m_rdata;
                end
            end
        end
    end

    // CPU stall counter, saturating so long debug holds never wrap it.
    always_ff @(posedge clk) begin
        if (areset) begin
            c_wait_cnt_r <= 16'd0;
        end else if (c_req && !c_ack && c_wait_cnt_r != 16'hFFFF) begin
            c_wait_cnt_r <= c_wait_cnt_r + 16'd1;
        end
    end

    // Strobes are gated by reset so an interrupted access neither writes nor acks.
    assign m_en       = (state_r == ST_ACCESS) & ~areset;
    assign m_we       = m_en & lat_we_r;
    assign m_addr     = lat_addr_r;
    assign m_wdata    = lat_wdata_r;
    assign c_ack      = (state_r == ST_RESP) & ~sel_dbg_r & ~areset;
    assign d_ack      = (state_r == ST_RESP) &  sel_dbg_r & ~areset;
    assign c_rdata    = c_rdata_r;
    assign d_rdata    = d_rdata_r;
    assign c_wait_cnt = c_wait_cnt_r;

endmodule

// File: tb/tb_subleq_mem_arbiter.sv
// Directed bench for subleq_mem_arbiter with a behavioural memory and an ack/rdata scoreboard.
module tb_subleq_mem_arbiter;

    logic        clk;
    logic        areset;
    logic        c_req, c_we, c_ack;
    logic [15:0] c_addr, c_wdata, c_rdata;
    logic        d_req, d_we, d_ack, d_hold;
    logic [15:0] d_addr, d_wdata, d_rdata;
    logic        m_en, m_we;
    logic [15:0] m_addr, m_wdata, m_rdata;
    logic [15:0] c_wait_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          dbg;
        bit          we;
        logic [15:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    bit          pend_c = 1'b0;
    bit          pend_d = 1'b0;
    logic [15:0] pend_c_val;
    logic [15:0] pend_d_val;
    bit [15:0]   mem [65536];

    subleq_mem_arbiter #(.WORD_SIZE(16)) dut (
        .clk(clk), .areset(areset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_hold(d_hold),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .c_wait_cnt(c_wait_cnt)
    );

    always #5 clk = ~clk;

    // Single-port synchronous memory: read data valid the cycle after m_en.
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) mem[m_addr] <= m_wdata;
            else      m_rdata <= mem[m_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every ack must match the next expected transaction; reads checked a cycle later.
    always @(negedge clk) begin
        exp_t e;
        if (pend_c) begin check("c_rdata", c_rdata, pend_c_val); pend_c = 1'b0; end
        if (pend_d) begin check("d_rdata", d_rdata, pend_d_val); pend_d = 1'b0; end
        if (c_ack || d_ack) begin
            check("ack_exclusive", c_ack & d_ack, 1'b0);
            if (sb_q.size() == 0) begin
                check("unexpected_ack", {c_ack, d_ack}, 2'b00);
            end else begin
                e = sb_q.pop_front();
                check("ack_port_is_dbg", d_ack, e.dbg);
                if (!e.we) begin
                    if (e.dbg) begin pend_d = 1'b1; pend_d_val = e.rdata; end
                    else       begin pend_c = 1'b1; pend_c_val = e.rdata; end
                end
            end
        end
    end

    task automatic push(input bit dbg, input bit we, input logic [15:0] rdata);
        exp_t e;
        e.dbg = dbg; e.we = we; e.rdata = rdata;
        sb_q.push_back(e);
    endtask

    task automatic wait_ack(input bit dbg, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(dbg ? d_ack : c_ack) && n < 20);
    endtask

    task automatic do_reset();
        @(negedge clk);
        areset = 1'b1;
        c_req = 1'b0; d_req = 1'b0; d_hold = 1'b0;
        repeat (2) @(negedge clk);
        areset = 1'b0;
    endtask

    initial begin
        int n;
        bit acc;
        clk = 1'b0; areset = 1'b1;
        c_req = 1'b0; c_we = 1'b0; c_addr = 16'h0; c_wdata = 16'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 16'h0; d_wdata = 16'h0; d_hold = 1'b0;
        mem[16'h0010] = 16'h1234;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_c_ack", c_ack, 1'b0);
        check("rst_d_ack", d_ack, 1'b0);
        check("rst_m_en", m_en, 1'b0);
        check("rst_c_rdata", c_rdata, 16'h0);
        check("rst_d_rdata", d_rdata, 16'h0);
        check("rst_wait_cnt", c_wait_cnt, 16'h0);
        check("rst_m_addr", m_addr, 16'h0);

        // CPU read of 0x0010
        areset = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0010;
        push(1'b0, 1'b0, 16'h1234);
        @(negedge clk);
        check("rd_m_en", m_en, 1'b1);
        check("rd_m_we", m_we, 1'b0);
        check("rd_m_addr", m_addr, 16'h0010);
        @(negedge clk);
        check("rd_c_ack", c_ack, 1'b1);
        c_req = 1'b0;
        @(negedge clk);
        check("rd_ack_pulse", c_ack, 1'b0);
        check("rd_m_en_idle", m_en, 1'b0);
        check("rd_m_addr_hold", m_addr, 16'h0010);
        check("rd_wait_cnt", c_wait_cnt, 16'd2);

        // Debug write 0xFE00 <= 0x00AA, then CPU read back
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'hFE00; d_wdata = 16'h00AA;
        push(1'b1, 1'b1, 16'h0);
        wait_ack(1'b1, n);
        check("dw_latency", n, 2);
        d_req = 1'b0;
        @(negedge clk);
        check("dw_ack_pulse", d_ack, 1'b0);
        check("dw_d_rdata_kept", d_rdata, 16'h0);
        check("dw_mem", mem[16'hFE00], 16'h00AA);
        c_req = 1'b1; c_we = 1'b0; c_addr = 16'hFE00;
        push(1'b0, 1'b0, 16'h00AA);
        wait_ack(1'b0, n);
        check("cr_latency", n, 2);
        c_req = 1'b0;
        @(negedge clk);

        // Contention after reset: C, D, C, D
        do_reset();
        c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'hFE00;
        push(1'b0, 1'b0, 16'h1234);
        push(1'b1, 1'b0, 16'h00AA);
        push(1'b0, 1'b0, 16'h1234);
        push(1'b1, 1'b0, 16'h00AA);
        wait_ack(1'b0, n); check("rr_c1", n, 2);
        wait_ack(1'b1, n); check("rr_d1", n, 3);
        wait_ack(1'b0, n); check("rr_c2", n, 3);
        c_req = 1'b0;
        wait_ack(1'b1, n); check("rr_d2", n, 3);
        d_req = 1'b0;
        check("rr_wait_cnt", c_wait_cnt, 16'd7);
        @(negedge clk);
        check("rr_sb_empty", sb_q.size(), 0);

        // d_hold blocks the CPU for 10 cycles
        do_reset();
        d_hold = 1'b1;
        c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0010;
        acc = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            acc = acc | m_en | c_ack;
        end
        check("hold_no_activity", acc, 1'b0);
        check("hold_wait_cnt", c_wait_cnt, 16'd10);
        d_hold = 1'b0;
        push(1'b0, 1'b0, 16'h1234);
        wait_ack(1'b0, n);
        check("hold_release_latency", n, 2);
        c_req = 1'b0;
        check("hold_wait_cnt2", c_wait_cnt, 16'd12);
        @(negedge clk);
        // d_hold rising mid-transaction must not abort it
        c_req = 1'b1; c_addr = 16'hFE00;
        push(1'b0, 1'b0, 16'h00AA);
        @(negedge clk);
        d_hold = 1'b1;
        wait_ack(1'b0, n);
        check("hold_mid_txn", n, 1);
        c_req = 1'b0; d_hold = 1'b0;
        @(negedge clk);

        // Reset during ACCESS of a debug write
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'hBEEF;
        @(negedge clk);
        check("ra_m_en_before", m_en, 1'b1);
        areset = 1'b1; d_req = 1'b0;
        #1;
        check("ra_m_we_gated", m_we, 1'b0);
        check("ra_m_en_gated", m_en, 1'b0);
        @(negedge clk);
        areset = 1'b0;
        #1;
        check("ra_idle_m_en", m_en, 1'b0);
        check("ra_no_d_ack", d_ack, 1'b0);
        @(negedge clk);
        check("ra_no_d_ack2", d_ack, 1'b0);
        check("ra_mem_untouched", mem[16'h0020], 16'h0000);

        // Wait counter saturation
        do_reset();
        d_hold = 1'b1; c_req = 1'b1;
        repeat (70000) @(negedge clk);
        check("sat_wait_cnt", c_wait_cnt, 16'hFFFF);
        check("sat_no_ack", c_ack, 1'b0);
        c_req = 1'b0; d_hold = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
